mul_selftest: RTL and testbench

Parametrised, self-contained self-test engine for pipelined W-bit signed/unsigned multipliers. It generalises the fixed 32-bit LFSR tester: operand width, DUT latency and run length are parameters. The multiplier under test is external. The block adds run control (start/abort), a vector count with a deterministic per-vector signed/unsigned mode, a saturating error counter, first-failure capture and a done/pass status. It sits beside a multiplier instance (for example `mul32p`) on FPGA or in simulation, and drives the DUT's operand/mode inputs while checking its hi/lo outputs.

---
 rtl/mul_selftest.sv | 183 ++++++++++++++++++
 tb/tb_mul_selftest.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_selftest.sv
// rtl/mul_selftest.sv - LFSR-driven self-test engine for an external pipelined multiplier
module mul_selftest #(
    parameter int             W      = 32,
    parameter int             LAT    = 8,
    parameter int             NVEC   = 1024,
    parameter int             CW     = 32,
    parameter logic [W-1:0]   SEED_A = 32'h0000_0001,
    parameter logic [W-1:0]   SEED_B = 32'hDEAD_BEEF,
    parameter logic [W-1:0]   MASK_A = 32'h8020_0003,
    parameter logic [W-1:0]   MASK_B = 32'h8000_0063
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic [W-1:0]               dut_a,
    output logic [W-1:0]               dut_b,
    output logic                       dut_mode,
    input  logic [W-1:0]               dut_hi,
    input  logic [W-1:0]               dut_lo,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CW-1:0]              err_count,
    output logic [$clog2(NVEC)-1:0]    first_err_idx,
    output logic [2*W-1:0]             first_err_exp,
    output logic [2*W-1:0]             first_err_got
);

    localparam int            IW       = $clog2(NVEC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NVEC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q;
    state_t state_d;

    // lfsr_a/lfsr_b always hold the operands of the next vector to issue
    logic [W-1:0]   lfsr_a;
    logic [W-1:0]   lfsr_b;
    logic [IW-1:0]  vec_idx;

    // Expected-result pipeline; stage 0 is loaded alongside the operand registers
    logic           pipe_v   [0:LAT];
    logic [2*W-1:0] pipe_exp [0:LAT];
    logic [IW-1:0]  pipe_idx [0:LAT];

    logic           start_acc;
    logic           abort_acc;
    logic           issue;
    logic [W-1:0]   issue_a;
    logic [W-1:0]   issue_b;
    logic [IW-1:0]  issue_idx;
    logic           issue_mode;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] exp_now;
    logic [2*W-1:0] got_now;
    logic           last_cmp;
    logic           mismatch;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] q, input logic [W-1:0] mask);
        return {q[W-2:0], ^(q & mask)};
    endfunction

    // Run-control decode and the expected product of the vector issued this edge
    always_comb begin
        start_acc  = start && (state_q == S_IDLE || state_q == S_DONE);
        abort_acc  = abort && (state_q == S_RUN || state_q == S_DRAIN);
        issue      = start_acc || (state_q == S_RUN && !abort);
        issue_a    = (state_q == S_RUN) ? lfsr_a  : SEED_A;
        issue_b    = (state_q == S_RUN) ? lfsr_b  : SEED_B;
        issue_idx  = (state_q == S_RUN) ? vec_idx : '0;
        issue_mode = issue_idx[0];
        // Sign- or zero-extend to 2W; the low 2W bits of the product are then exact
        ext_a      = issue_mode ? {{W{issue_a[W-1]}}, issue_a} : {{W{1'b0}}, issue_a};
        ext_b      = issue_mode ? {{W{issue_b[W-1]}}, issue_b} : {{W{1'b0}}, issue_b};
        exp_now    = ext_a * ext_b;
        got_now    = {dut_hi, dut_lo};
        last_cmp   = pipe_v[LAT] && (pipe_idx[LAT] == LAST_IDX);
        // A compare coinciding with an accepted abort is discarded along with the run
        mismatch   = pipe_v[LAT] && !abort_acc && (got_now != pipe_exp[LAT]);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides the normal progression
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (abort)                     state_d = S_IDLE;
                else if (vec_idx == LAST_IDX)  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)         state_d = S_IDLE;
                else if (last_cmp) state_d = S_DONE;
            end
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
        pass = (state_q == S_DONE) && (err_count == '0);
    end

    // Operand issue: drive the DUT and step both LFSRs once per vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dut_a    <= '0;
            dut_b    <= '0;
            dut_mode <= 1'b0;
            lfsr_a   <= '0;
            lfsr_b   <= '0;
            vec_idx  <= '0;
        end else if (issue) begin
            dut_a    <= issue_a;
            dut_b    <= issue_b;
            dut_mode <= issue_mode;
            lfsr_a   <= lfsr_step(issue_a, MASK_A);
            lfsr_b   <= lfsr_step(issue_b, MASK_B);
            vec_idx  <= issue_idx + IW'(1);
        end
    end

    // Expected-result delay line, flushed on abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_exp[i] <= '0;
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= issue;
            pipe_exp[0] <= exp_now;
            pipe_idx[0] <= issue_idx;
            for (int i = 1; i <= LAT; i++) begin
                pipe_v[i]   <= abort_acc ? 1'b0 : pipe_v[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    // Error accounting: saturating count plus capture of the first mismatch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (start_acc) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + CW'(1);
            end
            // err_count never wraps back to zero, so zero means nothing captured yet
            if (err_count == '0) begin
                first_err_idx <= pipe_idx[LAT];
                first_err_exp <= pipe_exp[LAT];
                first_err_got <= got_now;
            end
        end
    end

endmodule

// File: tb/tb_mul_selftest.sv
// tb/tb_mul_selftest.sv - self-checking bench for mul_selftest
module tb_mul_selftest;

    localparam logic [31:0] SA = 32'h0000_0001;
    localparam logic [31:0] SB = 32'hDEAD_BEEF;
    localparam logic [31:0] MA = 32'h8020_0003;
    localparam logic [31:0] MB = 32'h8000_0063;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, abort1, start2, abort2;
    logic [31:0] a1, b1, hi1, lo1, a2, b2, hi2, lo2;
    logic        m1, m2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [31:0] err1;
    logic [2:0]  err2;
    logic [3:0]  fidx1, fidx2;
    logic [63:0] fexp1, fgot1, fexp2, fgot2;

    logic [31:0] ref_a [0:15];
    logic [31:0] ref_b [0:15];
    logic [15:0] inj_mask = 16'h0;
    int          inj_bit  = 0;

    logic [63:0] q1 [1:8];
    logic [63:0] q2 [1:7];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_selftest #(.W(32), .LAT(8), .NVEC(16), .CW(32)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .dut_a(a1), .dut_b(b1), .dut_mode(m1), .dut_hi(hi1), .dut_lo(lo1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(fidx1), .first_err_exp(fexp1), .first_err_got(fgot1)
    );

    mul_selftest #(.W(32), .LAT(8), .NVEC(16), .CW(3)) u_sat (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .dut_a(a2), .dut_b(b2), .dut_mode(m2), .dut_hi(hi2), .dut_lo(lo2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_idx(fidx2), .first_err_exp(fexp2), .first_err_got(fgot2)
    );

    function automatic logic [31:0] step(input logic [31:0] q, input logic [31:0] mask);
        return {q[30:0], ^(q & mask)};
    endfunction

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic m);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (m) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    function automatic logic [63:0] ref_prod(input int k);
        logic [31:0] kk;
        kk = k;
        return mul_ref(ref_a[k], ref_b[k], kk[0]);
    endfunction

    function automatic logic [63:0] inj_term(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 16; k++)
            if (ref_a[k] == a && ref_b[k] == b && inj_mask[k]) return 64'h1 << inj_bit;
        return 64'h0;
    endfunction

    // Behavioural multipliers: 8-cycle one with fault injection, 7-cycle one for the latency test
    always @(posedge clk) begin
        q1[1] <= mul_ref(a1, b1, m1) ^ inj_term(a1, b1);
        for (int i = 2; i <= 8; i++) q1[i] <= q1[i-1];
        q2[1] <= mul_ref(a2, b2, m2);
        for (int i = 2; i <= 7; i++) q2[i] <= q2[i-1];
    end
    assign {hi1, lo1} = q1[8];
    assign {hi2, lo2} = q2[7];

    task automatic pulse_start1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
    endtask

    task automatic wait_done1(output int cyc);
        cyc = -1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (done1) begin cyc = c; break; end
        end
    endtask

    task automatic test_reset;
        #3;
        n_checks++; if ({a1, b1, m1, busy1, done1, pass1} !== 67'h0) begin n_fail++; $display("FAIL reset_ops: got %h required 0", {a1, b1, m1, busy1, done1, pass1}); end
        n_checks++; if ({err1, fidx1, fexp1, fgot1} !== 164'h0) begin n_fail++; $display("FAIL reset_err: got %h required 0", {err1, fidx1, fexp1, fgot1}); end
        n_checks++; if ({busy2, done2, err2, a2} !== 37'h0) begin n_fail++; $display("FAIL reset_sat: got %h required 0", {busy2, done2, err2, a2}); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({busy1, done1, err1} !== 34'h0) begin n_fail++; $display("FAIL reset_release: got %h required 0", {busy1, done1, err1}); end
    endtask

    task automatic test_basic_pass;
        int cyc = -1;
        int bad = 0;
        inj_mask = 16'h0;
        pulse_start1;
        n_checks++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL basic_busy0: got %b required 10", {busy1, done1}); end
        n_checks++; if ({a1, b1, m1} !== {32'h0000_0001, 32'hDEAD_BEEF, 1'b0}) begin n_fail++; $display("FAIL basic_vec0: got %h required %h", {a1, b1, m1}, {32'h0000_0001, 32'hDEAD_BEEF, 1'b0}); end
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (c < 16 && (a1 !== ref_a[c] || b1 !== ref_b[c] || m1 !== c[0])) bad++;
            if (done1) begin cyc = c; break; end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL basic_vectors: got %0d bad vectors required 0", bad); end
        n_checks++; if (cyc !== 24) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 24", cyc); end
        n_checks++; if ({pass1, busy1, err1} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL basic_status: got %h required %h", {pass1, busy1, err1}, {1'b1, 1'b0, 32'h0}); end
    endtask

    task automatic test_inject;
        int cyc;
        logic [63:0] e5;
        inj_mask = 16'h0220;
        inj_bit  = 0;
        e5 = ref_prod(5);
        pulse_start1;
        wait_done1(cyc);
        n_checks++; if (cyc !== 24) begin n_fail++; $display("FAIL inj_done_cycle: got %0d required 24", cyc); end
        n_checks++; if (err1 !== 32'd2) begin n_fail++; $display("FAIL inj_err_count: got %0d required 2", err1); end
        n_checks++; if (fidx1 !== 4'd5) begin n_fail++; $display("FAIL inj_first_idx: got %0d required 5", fidx1); end
        n_checks++; if (fexp1 !== e5) begin n_fail++; $display("FAIL inj_first_exp: got %h required %h", fexp1, e5); end
        n_checks++; if (fgot1 !== (e5 ^ 64'h1)) begin n_fail++; $display("FAIL inj_first_got: got %h required %h", fgot1, e5 ^ 64'h1); end
        n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL inj_pass: got %b required 0", pass1); end
    endtask

    task automatic test_random_errors;
        for (int it = 0; it < 4; it++) begin
            int cyc, cnt, first;
            logic [63:0] ex, gx;
            inj_mask = 16'($urandom_range(0, 65535));
            inj_bit  = $urandom_range(0, 63);
            cnt = $countones(inj_mask);
            first = 0;
            for (int k = 15; k >= 0; k--) if (inj_mask[k]) first = k;
            ex = (cnt > 0) ? ref_prod(first) : 64'h0;
            gx = (cnt > 0) ? (ex ^ (64'h1 << inj_bit)) : 64'h0;
            pulse_start1;
            wait_done1(cyc);
            n_checks++; if (err1 !== 32'(cnt)) begin n_fail++; $display("FAIL rand_err_count mask %h: got %0d required %0d", inj_mask, err1, cnt); end
            n_checks++; if ({fidx1, fexp1, fgot1} !== {4'(first), ex, gx}) begin n_fail++; $display("FAIL rand_first mask %h: got %h required %h", inj_mask, {fidx1, fexp1, fgot1}, {4'(first), ex, gx}); end
            n_checks++; if ({done1, pass1} !== {1'b1, cnt == 0}) begin n_fail++; $display("FAIL rand_status mask %h: got %b required %b", inj_mask, {done1, pass1}, {1'b1, cnt == 0}); end
        end
    endtask

    task automatic test_saturate;
        int cyc = -1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (done2) begin cyc = c; break; end
        end
        n_checks++; if (cyc !== 24) begin n_fail++; $display("FAIL sat_done_cycle: got %0d required 24", cyc); end
        n_checks++; if (err2 !== 3'd7) begin n_fail++; $display("FAIL sat_err_count: got %0d required 7", err2); end
        n_checks++; if ({pass2, fidx2} !== 5'h0) begin n_fail++; $display("FAIL sat_pass_idx: got %h required 0", {pass2, fidx2}); end
        n_checks++; if (fexp2 !== ref_prod(0)) begin n_fail++; $display("FAIL sat_first_exp: got %h required %h", fexp2, ref_prod(0)); end
        n_checks++; if (fgot2 !== ref_prod(1)) begin n_fail++; $display("FAIL sat_first_got: got %h required %h", fgot2, ref_prod(1)); end
    endtask

    task automatic test_abort;
        int bad = 0;
        inj_mask = 16'hFFFF;
        inj_bit  = 3;
        pulse_start1;
        repeat (7) @(negedge clk);
        n_checks++; if ({busy1, a1, err1} !== {1'b1, ref_a[7], 32'h0}) begin n_fail++; $display("FAIL abort_pre: got %h required %h", {busy1, a1, err1}, {1'b1, ref_a[7], 32'h0}); end
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        n_checks++; if ({busy1, done1} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got %b required 00", {busy1, done1}); end
        n_checks++; if ({a1, b1} !== {ref_a[7], ref_b[7]}) begin n_fail++; $display("FAIL abort_hold_ops: got %h required %h", {a1, b1}, {ref_a[7], ref_b[7]}); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (err1 !== 32'h0 || busy1 !== 1'b0 || done1 !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_frozen: got %0d bad cycles required 0", bad); end
    endtask

    task automatic test_reset_drain;
        int cyc;
        inj_mask = 16'h0;
        pulse_start1;
        repeat (18) @(negedge clk);
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b required 1", busy1); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({a1, b1, m1, busy1, done1, pass1, err1, fidx1, fexp1, fgot1} !== 231'h0) begin n_fail++; $display("FAIL drain_async_reset: got %h required 0", {a1, b1, m1, busy1, done1, pass1, err1, fidx1, fexp1, fgot1}); end
        @(negedge clk);
        rst = 1'b1;
        pulse_start1;
        wait_done1(cyc);
        n_checks++; if ({cyc == 24, pass1, err1} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL drain_restart: got cyc %0d pass %b err %0d required 24 1 0", cyc, pass1, err1); end
    endtask

    task automatic test_back_to_back;
        int cyc = -1;
        int bad = 0;
        inj_mask = 16'h0008;
        inj_bit  = 40;
        pulse_start1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start1 = (c == 3 || c == 20);
            if (done1) begin cyc = c; break; end
        end
        start1 = 1'b0;
        n_checks++; if (cyc !== 24) begin n_fail++; $display("FAIL b2b_ignored_start: got %0d required 24", cyc); end
        n_checks++; if ({err1, fidx1} !== {32'd1, 4'd3}) begin n_fail++; $display("FAIL b2b_run1_err: got %h required %h", {err1, fidx1}, {32'd1, 4'd3}); end
        inj_mask = 16'h0;
        pulse_start1;
        n_checks++; if ({done1, pass1, err1, fidx1, fexp1, fgot1} !== 166'h0) begin n_fail++; $display("FAIL b2b_cleared: got %h required 0", {done1, pass1, err1, fidx1, fexp1, fgot1}); end
        if (a1 !== ref_a[0] || b1 !== ref_b[0]) bad++;
        cyc = -1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (c < 16 && (a1 !== ref_a[c] || b1 !== ref_b[c])) bad++;
            if (done1) begin cyc = c; break; end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_sequence: got %0d bad vectors required 0", bad); end
        n_checks++; if ({cyc == 24, pass1} !== 2'b11) begin n_fail++; $display("FAIL b2b_run2: got cyc %0d pass %b required 24 1", cyc, pass1); end
    endtask

    initial begin
        rst = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        ref_a[0] = SA;
        ref_b[0] = SB;
        for (int k = 1; k < 16; k++) begin
            ref_a[k] = step(ref_a[k-1], MA);
            ref_b[k] = step(ref_b[k-1], MB);
        end
        test_reset;
        test_basic_pass;
        test_inject;
        test_random_errors;
        test_saturate;
        test_abort;
        test_reset_drain;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
